data_memory_be: RTL and testbench

DATA_MEMORY_BE -- requirements
Module: data_memory_be

---
 rtl/data_memory_be_pkg.sv | 40 ++++
 rtl/data_memory_be_if.sv | 27 ++
 rtl/data_memory_be_load_extract.sv | 21 ++
 rtl/data_memory_be.sv | 129 ++++++++++++
 tb/tb_data_memory_be.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_be_pkg.sv
// Shared encodings and byte-lane helpers for the byte-enable data memory.
// Alignment and lane masks are kept here so load and store paths agree.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dmem_state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      SZ_WORD: return (lane == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-justified store data replicated so every lane sees its slice.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Access bus between a load/store unit and the data memory.
interface data_memory_be_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH+1:0] addr;
  logic [31:0]           wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            size;
  logic                  sign_ext;
  logic                  dev_access;
  logic                  clear_req;
  logic [31:0]           rdata;
  logic                  rvalid;
  logic                  misaligned;
  logic                  busy;

  modport master (
    output addr, wdata, mem_read, mem_write, size, sign_ext, dev_access, clear_req,
    input  rdata, rvalid, misaligned, busy
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write, size, sign_ext, dev_access, clear_req,
    output rdata, rvalid, misaligned, busy
  );
endinterface

// File: rtl/data_memory_be_load_extract.sv
// Load data alignment: moves the addressed lane(s) to bit 0 and extends.
module dmem_load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);
  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end
endmodule

// File: rtl/data_memory_be.sv
// Byte-enable data memory with registered loads and a zeroing sweep
// after reset or on request.
//
// state    | meaning
// ST_CLEAR | sweep writes 0 to word clr_ptr each cycle, bus ignored
// ST_IDLE  | loads/stores accepted
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  data_memory_be_if.slave bus
);
  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  dmem_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nxt;
  logic                  busy_int;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            lane;
  logic                  req, legal, rd_acc, wr_acc, mis_nxt;
  logic [3:0]            st_mask;
  logic [31:0]           st_data;

  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [31:0]           ram_wdata;
  logic [31:0]           rd_word;

  logic                  rvalid_q, mis_q, ld_sext;
  logic [1:0]            ld_lane, ld_size;
  logic [31:0]           ld_result;

  assign busy_int  = (state == ST_CLEAR);
  assign word_addr = bus.addr[ADDR_WIDTH+1:2];
  assign lane      = bus.addr[1:0];
  assign req       = !busy_int && (bus.mem_read || bus.mem_write) && !bus.dev_access;
  assign legal     = is_aligned(bus.size, lane);
  assign rd_acc    = req && legal && bus.mem_read;
  assign wr_acc    = req && legal && bus.mem_write;
  assign mis_nxt   = req && !legal;
  assign st_mask   = lane_mask(bus.size, lane);
  assign st_data   = store_data(bus.size, bus.wdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_CLEAR: begin
        if (clr_ptr == LAST_WORD) begin
          state_nxt   = ST_IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + PTR_ONE;
        end
      end
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
    endcase
  end

  // The sweep owns the write port; bus stores are already blocked while busy.
  assign ram_we    = busy_int ? 4'hF : (wr_acc ? st_mask : 4'h0);
  assign ram_waddr = busy_int ? clr_ptr : word_addr;
  assign ram_wdata = busy_int ? 32'h0 : st_data;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane_ram [DEPTH];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (rd_acc) rd_byte <= lane_ram[word_addr];
      if (ram_we[i]) lane_ram[ram_waddr] <= ram_wdata[8*i +: 8];
    end
  end

  assign rd_word = {g_lane[3].rd_byte, g_lane[2].rd_byte, g_lane[1].rd_byte, g_lane[0].rd_byte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      ld_lane  <= 2'b00;
      ld_size  <= SZ_BYTE;
      ld_sext  <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      mis_q    <= mis_nxt;
      if (rd_acc) begin
        ld_lane <= lane;
        ld_size <= bus.size;
        ld_sext <= bus.sign_ext;
      end
    end
  end

  dmem_load_extract u_load_extract (
    .word     (rd_word),
    .lane     (ld_lane),
    .size     (ld_size),
    .sign_ext (ld_sext),
    .result   (ld_result)
  );

  assign bus.rdata      = rvalid_q ? ld_result : 32'h0;
  assign bus.rvalid     = rvalid_q;
  assign bus.misaligned = mis_q;
  assign bus.busy       = busy_int;
endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: directed cases plus random traffic against a
// byte-array reference model.
module tb_data_memory_be;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int NBYTES = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_mem [NBYTES];

  data_memory_be_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_be #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input int sz);
    return (sz == 0) ? 1 : ((sz == 1) ? 2 : 4);
  endfunction

  function automatic bit legal(input int a, input int sz);
    return (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
  endfunction

  function automatic logic [31:0] model_load(input int a, input int sz, input bit sx);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v += longint'(model_mem[a + i]) << (8 * i);
    if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic bus_idle();
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.size       = 2'b00;
    bus.sign_ext   = 1'b0;
    bus.dev_access = 1'b0;
    bus.clear_req  = 1'b0;
  endtask

  task automatic access(input bit rd, input bit wr, input int sz, input bit sx, input bit dev,
                        input int a, input logic [31:0] wd, input string tag,
                        output logic [31:0] got);
    bit ok, exp_v, exp_m;
    logic [31:0] exp_d;
    ok    = legal(a, sz);
    exp_v = rd && !dev && ok;
    exp_m = (rd || wr) && !dev && !ok;
    exp_d = exp_v ? model_load(a, sz, sx) : 32'h0;
    bus.addr       = a[AW+1:0];
    bus.wdata      = wd;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.size       = sz[1:0];
    bus.sign_ext   = sx;
    bus.dev_access = dev;
    @(posedge clk);
    #1;
    got = bus.rdata;
    check({tag, ".rvalid"}, 32'(bus.rvalid), 32'(exp_v));
    check({tag, ".rdata"}, bus.rdata, exp_d);
    check({tag, ".misaligned"}, 32'(bus.misaligned), 32'(exp_m));
    bus_idle();
    if (wr && !dev && ok)
      for (int i = 0; i < nbytes(sz); i++) model_mem[a + i] = int'((wd >> (8 * i)) & 32'hFF);
  endtask

  // Counts edges spent busy; optionally hammers the bus (incl. clear_req) meanwhile.
  task automatic count_busy(input string tag, input bit try_access);
    int cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      if (try_access) begin
        bus.addr      = 6'($urandom_range(0, 63)) & 6'h3C;
        bus.wdata     = $urandom;
        bus.mem_read  = 1'($urandom_range(0, 1));
        bus.mem_write = 1'b1;
        bus.size      = 2'($urandom_range(0, 3));
        bus.clear_req = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      cnt++;
      if (try_access) begin
        check({tag, ".rvalid_busy"}, 32'(bus.rvalid), 32'h0);
        check({tag, ".mis_busy"}, 32'(bus.misaligned), 32'h0);
      end
      bus_idle();
    end
    check({tag, ".busy_cycles"}, 32'(cnt), 32'(DEPTH));
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 0;
  endtask

  task automatic read_all(input string tag);
    logic [31:0] got;
    for (int w = 0; w < DEPTH; w++) begin
      access(1'b1, 1'b0, 2, 1'b0, 1'b0, w * 4, 32'h0, tag, got);
      check({tag, ".zero"}, got, 32'h0);
    end
  endtask

  task automatic random_traffic(input int n);
    logic [31:0] got;
    int a, sz;
    for (int k = 0; k < n; k++) begin
      a  = int'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a & ~3;
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), a, $urandom, "rand", got);
    end
  endtask

  initial begin
    logic [31:0] got;
    bus_idle();
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 32'h1);
    check("reset.rvalid", 32'(bus.rvalid), 32'h0);
    check("reset.rdata", bus.rdata, 32'h0);
    check("reset.misaligned", 32'(bus.misaligned), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    count_busy("por", 1'b0);
    read_all("por_rd");

    access(1'b0, 1'b1, 2, 1'b0, 1'b0, 8, 32'h80FF7F01, "sw8", got);
    access(1'b1, 1'b0, 0, 1'b1, 1'b0, 8, 32'h0, "lb8", got);
    check("lb8.lit", got, 32'h00000001);
    access(1'b1, 1'b0, 0, 1'b1, 1'b0, 11, 32'h0, "lbB", got);
    check("lbB.lit", got, 32'hFFFFFF80);
    access(1'b1, 1'b0, 0, 1'b0, 1'b0, 10, 32'h0, "lbuA", got);
    check("lbuA.lit", got, 32'h000000FF);
    access(1'b1, 1'b0, 1, 1'b1, 1'b0, 10, 32'h0, "lhA", got);
    check("lhA.lit", got, 32'hFFFF80FF);

    access(1'b0, 1'b1, 2, 1'b0, 1'b0, 8, 32'h11223344, "sw8b", got);
    access(1'b0, 1'b1, 0, 1'b0, 1'b0, 9, 32'h000000AA, "sb9", got);
    access(1'b1, 1'b0, 2, 1'b0, 1'b0, 8, 32'h0, "lw8", got);
    check("lw8.lit", got, 32'h1122AA44);
    access(1'b0, 1'b1, 1, 1'b0, 1'b0, 3, 32'h00000001, "sh3", got);
    access(1'b1, 1'b0, 2, 1'b0, 1'b0, 0, 32'h0, "lw0", got);
    check("lw0.lit", got, 32'h0);

    access(1'b0, 1'b1, 2, 1'b0, 1'b0, 4, 32'h5, "sw4", got);
    access(1'b1, 1'b1, 2, 1'b0, 1'b0, 4, 32'h6, "rw4", got);
    check("rw4.lit", got, 32'h5);
    access(1'b1, 1'b0, 2, 1'b0, 1'b0, 4, 32'h0, "lw4", got);
    check("lw4.lit", got, 32'h6);

    access(1'b0, 1'b1, 2, 1'b0, 1'b1, 0, 32'hDEADBEEF, "dev0", got);
    access(1'b1, 1'b0, 2, 1'b0, 1'b0, 0, 32'h0, "dev0_lw", got);
    check("dev0_lw.lit", got, 32'h0);

    random_traffic(300);

    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    count_busy("clr", 1'b1);
    read_all("clr_rd");

    random_traffic(60);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("midrst.busy", 32'(bus.busy), 32'h1);
    check("midrst.rvalid", 32'(bus.rvalid), 32'h0);
    reset = 1'b1;
    count_busy("midrst", 1'b0);
    read_all("midrst_rd");
    random_traffic(100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
